// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state, opcode and select encodings shared by the RV32I multicycle controller and datapath.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        return op == OP_SW  ? IMM_S :
               op == OP_BEQ ? IMM_B :
               op == OP_JAL ? IMM_J : IMM_I;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp and instruction funct fields to the ALU operation.
module alu_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic [1:0]            i_alu_op,
    input  logic [2:0]            i_funct3,
    input  logic                  i_funct7b5,
    input  logic                  i_op5,
    output logic [ALU_CTRL_W-1:0] o_alu_control
);

    logic [2:0] w_funct_op;
    logic [2:0] w_ctrl;

    // Only R-type (op5=1) with funct7b5 set is a subtract; addi ignores Instr[30].
    always_comb begin
        w_funct_op = i_funct3 == 3'b000 ? ((i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD) :
                     i_funct3 == 3'b010 ? ALU_SLT :
                     i_funct3 == 3'b110 ? ALU_OR  :
                     i_funct3 == 3'b111 ? ALU_AND : ALU_ADD;
        w_ctrl     = i_alu_op == ALUOP_SUB   ? ALU_SUB    :
                     i_alu_op == ALUOP_FUNCT ? w_funct_op : ALU_ADD;
    end

    assign o_alu_control = ALU_CTRL_W'(w_ctrl);

endmodule

// File: rtl/main_fsm_controller.sv
// main_fsm_controller: Moore FSM sequencing the RV32I multicycle datapath.
module main_fsm_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  Zero,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic                  RegWrite,
    output logic [1:0]            ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  IllegalOp
);

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic [1:0] w_alu_op;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = FETCH;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        w_alu_op    = ALUOP_ADD;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_WD;
        case (r_state)
            FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_update = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                w_next      = DECODE;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_R:         w_next = EXECR;
                    OP_I:         w_next = EXECI;
                    OP_BEQ:       w_next = BEQ;
                    OP_JAL:       w_next = JAL;
                    default:      w_illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                w_next  = op == OP_LW ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc   = RES_DATA;
                w_reg_write = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            EXECR: begin
                ALUSrcA  = SRCA_A;
                w_alu_op = ALUOP_FUNCT;
                w_next   = ALUWB;
            end
            EXECI: begin
                ALUSrcA  = SRCA_A;
                ALUSrcB  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
                w_next   = ALUWB;
            end
            ALUWB: w_reg_write = 1'b1;
            BEQ: begin
                ALUSrcA  = SRCA_A;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
            end
            JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                w_pc_update = 1'b1;
                w_next      = ALUWB;
            end
            default: w_next = FETCH;
        endcase
    end

    // Enables are gated by reset so an aborted instruction leaves no side effects.
    assign PCWrite   = reset & (w_pc_update | (w_branch & Zero));
    assign IRWrite   = reset & w_ir_write;
    assign RegWrite  = reset & w_reg_write;
    assign MemWrite  = reset & w_mem_write;
    assign IllegalOp = reset & w_illegal;
    assign ImmSrc    = imm_src(op);

    alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op5         (op[5]),
        .o_alu_control (ALUControl)
    );

endmodule
